// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: bundles every signal between the cache sequencer and its
// neighbours (pipeline memory stage, cache array, backing memory).
//   slave  : the cache_ctrl side. It receives CPU requests and array/memory
//            responses, and drives completion, array controls, memory
//            requests and statistics.
//   master : the environment side (CPU, cache array, main memory).
// Address width AW = TAG_WIDTH + 12 (tag | 8-bit index | 4-bit byte offset).
interface cache_ctrl_if #(
  parameter int TAG_WIDTH = 4
);
  localparam int AW = TAG_WIDTH + 12;

  // CPU side
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic [AW-1:0]        cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_done;
  logic                 cpu_stall;
  logic                 cpu_hit;
  logic                 cpu_err;

  // cache array controls and combinational outputs
  logic                 c_enable;
  logic                 c_comp;
  logic                 c_write;
  logic                 c_valid_in;
  logic [TAG_WIDTH-1:0] c_tag_in;
  logic [7:0]           c_index;
  logic [3:0]           c_offset;
  logic [31:0]          c_data_in;
  logic [TAG_WIDTH-1:0] c_tag_out;
  logic [31:0]          c_data_out;
  logic                 c_hit;
  logic                 c_dirty;
  logic                 c_valid;

  // backing memory
  logic                 mem_req;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_ready;
  logic [31:0]          mem_rdata;

  // statistics
  logic [15:0]          hit_count;
  logic [15:0]          miss_count;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall, cpu_hit, cpu_err,
    output c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
    input  c_tag_out, c_data_out, c_hit, c_dirty, c_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output hit_count, miss_count
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall, cpu_hit, cpu_err,
    input  c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
    output c_tag_out, c_data_out, c_hit, c_dirty, c_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencer for a direct-mapped cache array with 4-word lines.
// Serves single-word CPU loads/stores; handles hit, clean-miss fill and
// dirty-miss write-back against a word-wide backing memory.
//
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous, active-high reset
//   bus  - cache_ctrl_if.slave: CPU request/response, cache array controls
//          and outputs, memory request/response, hit/miss statistics
//
// Optional feature: define CACHE_CTRL_STATS_EN to build the saturating
// 16-bit hit/miss counters. Without it both counter outputs are tied to 0.
//
// State  | meaning
// IDLE   | waiting for a request; latches address/data/op
// COMPARE| tag compare (and write on hit); error requests complete here
// WB0-3  | write back word k of the dirty victim line
// FILL0-3| fetch word k of the requested line into the array
// RETRY  | replay the access on the freshly filled line
//
// The array outputs are combinational, so the array/memory controls decode
// the state register directly: they stay glitch-free per state and drop to
// zero the moment rst forces the state to IDLE.
module cache_ctrl #(
  parameter int TAG_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  cache_ctrl_if.slave   bus
);
  localparam int AW = TAG_WIDTH + 12;

  typedef enum logic [3:0] {
    S_IDLE, S_COMPARE,
    S_WB0, S_WB1, S_WB2, S_WB3,
    S_FILL0, S_FILL1, S_FILL2, S_FILL3,
    S_RETRY
  } state_t;

  state_t               state_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [7:0]           index_q;
  logic [3:0]           offset_q;
  logic [31:0]          wdata_q;
  logic                 wr_q;
  logic                 err_q;

  logic                 real_hit;
  logic [1:0]           word_k;
  logic                 in_wb;
  logic                 in_fill;

  assign real_hit = bus.c_hit & bus.c_valid;
  assign in_wb    = (state_q == S_WB0)   || (state_q == S_WB1)   ||
                    (state_q == S_WB2)   || (state_q == S_WB3);
  assign in_fill  = (state_q == S_FILL0) || (state_q == S_FILL1) ||
                    (state_q == S_FILL2) || (state_q == S_FILL3);

  always_comb begin
    word_k = 2'd0;
    case (state_q)
      S_WB1, S_FILL1: word_k = 2'd1;
      S_WB2, S_FILL2: word_k = 2'd2;
      S_WB3, S_FILL3: word_k = 2'd3;
      default:        word_k = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_rd || bus.cpu_wr) begin
            tag_q    <= bus.cpu_addr[AW-1:12];
            index_q  <= bus.cpu_addr[11:4];
            offset_q <= bus.cpu_addr[3:0];
            wdata_q  <= bus.cpu_wdata;
            wr_q     <= bus.cpu_wr;
            err_q    <= (bus.cpu_rd && bus.cpu_wr) || (bus.cpu_addr[1:0] != 2'b00);
            state_q  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (err_q || real_hit)               state_q <= S_IDLE;
          else if (bus.c_valid && bus.c_dirty) state_q <= S_WB0;
          else                                 state_q <= S_FILL0;
        end
        S_WB0:   if (bus.mem_ready) state_q <= S_WB1;
        S_WB1:   if (bus.mem_ready) state_q <= S_WB2;
        S_WB2:   if (bus.mem_ready) state_q <= S_WB3;
        S_WB3:   if (bus.mem_ready) state_q <= S_FILL0;
        S_FILL0: if (bus.mem_ready) state_q <= S_FILL1;
        S_FILL1: if (bus.mem_ready) state_q <= S_FILL2;
        S_FILL2: if (bus.mem_ready) state_q <= S_FILL3;
        S_FILL3: if (bus.mem_ready) state_q <= S_RETRY;
        S_RETRY: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic                 cpu_done, cpu_hit, cpu_err;
  logic [31:0]          cpu_rdata;
  logic                 c_enable, c_comp, c_write, c_valid_in;
  logic [TAG_WIDTH-1:0] c_tag_in;
  logic [7:0]           c_index;
  logic [3:0]           c_offset;
  logic [31:0]          c_data_in;
  logic                 mem_req, mem_we;
  logic [AW-1:0]        mem_addr;
  logic [31:0]          mem_wdata;

  always_comb begin
    cpu_done   = 1'b0;
    cpu_hit    = 1'b0;
    cpu_err    = 1'b0;
    cpu_rdata  = '0;
    c_enable   = 1'b0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    c_tag_in   = '0;
    c_index    = '0;
    c_offset   = '0;
    c_data_in  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if ((state_q == S_COMPARE) && err_q) begin
      cpu_done = 1'b1;
      cpu_err  = 1'b1;
    end else if ((state_q == S_COMPARE) || (state_q == S_RETRY)) begin
      // RETRY replays the compare access; the line is now resident, so a
      // store commits here and a load reads the filled word.
      c_enable  = 1'b1;
      c_comp    = 1'b1;
      c_write   = wr_q;
      c_tag_in  = tag_q;
      c_index   = index_q;
      c_offset  = offset_q;
      c_data_in = wdata_q;
      if (state_q == S_RETRY) begin
        cpu_done  = 1'b1;
        cpu_rdata = bus.c_data_out;
      end else if (real_hit) begin
        cpu_done  = 1'b1;
        cpu_hit   = 1'b1;
        cpu_rdata = bus.c_data_out;
      end
    end else if (in_wb) begin
      // Victim address comes from the stored tag of the line being evicted.
      c_enable  = 1'b1;
      c_index   = index_q;
      c_offset  = {word_k, 2'b00};
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {bus.c_tag_out, index_q, word_k, 2'b00};
      mem_wdata = bus.c_data_out;
    end else if (in_fill) begin
      mem_req  = 1'b1;
      mem_addr = {tag_q, index_q, word_k, 2'b00};
      if (bus.mem_ready) begin
        c_enable   = 1'b1;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        c_tag_in   = tag_q;
        c_index    = index_q;
        c_offset   = {word_k, 2'b00};
        c_data_in  = bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_done   = cpu_done;
  assign bus.cpu_hit    = cpu_hit;
  assign bus.cpu_err    = cpu_err;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_stall  = (state_q != S_IDLE) && !cpu_done;
  assign bus.c_enable   = c_enable;
  assign bus.c_comp     = c_comp;
  assign bus.c_write    = c_write;
  assign bus.c_valid_in = c_valid_in;
  assign bus.c_tag_in   = c_tag_in;
  assign bus.c_index    = c_index;
  assign bus.c_offset   = c_offset;
  assign bus.c_data_in  = c_data_in;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Only the first compare of a normal request counts; RETRY is not a lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if ((state_q == S_COMPARE) && !err_q) begin
      if (real_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = 16'd0;
  assign bus.miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural cache array and a
// word-wide memory whose default content is each word's own byte address.
module tb_cache_ctrl;
  localparam int TW = 4;

  logic clk;
  logic rst;

  cache_ctrl_if #(.TAG_WIDTH(TW)) bus ();

  cache_ctrl #(.TAG_WIDTH(TW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- cache array model ----------------
  logic [TW-1:0] tag_m   [256];
  logic          valid_m [256];
  logic          dirty_m [256];
  logic [31:0]   data_m  [1024];
  logic [9:0]    widx;
  logic          tag_match;

  assign widx           = {bus.c_index, bus.c_offset[3:2]};
  assign tag_match      = (tag_m[bus.c_index] == bus.c_tag_in);
  assign bus.c_tag_out  = tag_m[bus.c_index];
  assign bus.c_data_out = data_m[widx];
  assign bus.c_valid    = valid_m[bus.c_index];
  assign bus.c_dirty    = dirty_m[bus.c_index];
  assign bus.c_hit      = bus.c_enable && bus.c_comp && tag_match;

  // The array shares the controller reset, which invalidates every line.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        valid_m[i] <= 1'b0;
        dirty_m[i] <= 1'b0;
      end
    end else if (bus.c_enable && bus.c_write) begin
      if (bus.c_comp) begin
        if (tag_match && valid_m[bus.c_index]) begin
          data_m[widx]         <= bus.c_data_in;
          dirty_m[bus.c_index] <= 1'b1;
        end
      end else begin
        data_m[widx]         <= bus.c_data_in;
        tag_m[bus.c_index]   <= bus.c_tag_in;
        valid_m[bus.c_index] <= bus.c_valid_in;
        dirty_m[bus.c_index] <= 1'b0;
      end
    end
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_m [logic [15:0]];
  logic [31:0] mem_rd;
  int          mem_delay;
  int          wait_cnt;
  int          wr_count;

  always_comb begin
    mem_rd = {16'h0000, bus.mem_addr};
    if (mem_m.exists(bus.mem_addr)) mem_rd = mem_m[bus.mem_addr];
  end

  assign bus.mem_rdata = mem_rd;
  assign bus.mem_ready = bus.mem_req && (wait_cnt == mem_delay);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!bus.mem_req || bus.mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  initial wr_count = 0;
  always @(posedge clk) begin
    if (!rst && bus.mem_req && bus.mem_we && bus.mem_ready) begin
      mem_m[bus.mem_addr] = bus.mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  // Request lines must not move while a transfer is stretched.
  logic        hold_q;
  logic [15:0] haddr_q;
  logic [31:0] hwdata_q;
  logic        hwe_q;
  logic        unstable;
  initial begin
    hold_q   = 1'b0;
    unstable = 1'b0;
  end
  always @(negedge clk) begin
    if (!rst && hold_q &&
        (!bus.mem_req || bus.mem_addr != haddr_q ||
         bus.mem_wdata != hwdata_q || bus.mem_we != hwe_q))
      unstable = 1'b1;
    hold_q   = !rst && bus.mem_req && !bus.mem_ready;
    haddr_q  = bus.mem_addr;
    hwdata_q = bus.mem_wdata;
    hwe_q    = bus.mem_we;
  end

  // ---------------- checking ----------------
  int n_chk;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          r_cyc;
  logic [31:0] r_rdata;
  logic        r_hit;
  logic        r_err;
  logic        r_saw;

  // Issue one request; r_cyc is the cycle (after the accepting edge) in
  // which cpu_done was seen, or -1 on timeout.
  task automatic run_req(input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    r_cyc   = -1;
    r_rdata = '0;
    r_hit   = 1'b0;
    r_err   = 1'b0;
    r_saw   = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.mem_req || bus.c_enable) r_saw = 1'b1;
      if (bus.cpu_done) begin
        r_cyc   = c;
        r_rdata = bus.cpu_rdata;
        r_hit   = bus.cpu_hit;
        r_err   = bus.cpu_err;
        break;
      end
    end
  endtask

  int          wr0;
  logic        found;
  logic [15:0] exp_hits;
  logic [15:0] exp_miss;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    mem_delay = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done",  32'(bus.cpu_done),   32'd0);
    chk("rst_stall", 32'(bus.cpu_stall),  32'd0);
    chk("rst_memreq",32'(bus.mem_req),    32'd0);
    chk("rst_cen",   32'(bus.c_enable),   32'd0);
    chk("rst_hitcnt",32'(bus.hit_count),  32'd0);
    chk("rst_miscnt",32'(bus.miss_count), 32'd0);

    // cold read
    run_req(1'b1, 1'b0, 16'h0A18, 32'h0);
    chk("cold_cyc",   32'(r_cyc), 32'd6);
    chk("cold_rdata", r_rdata,    32'h0000_0A18);
    chk("cold_hit",   32'(r_hit), 32'd0);
    chk("cold_w0",    data_m[{8'hA1, 2'd0}], 32'h0000_0A10);
    chk("cold_w3",    data_m[{8'hA1, 2'd3}], 32'h0000_0A1C);

    // write hit then read hit
    run_req(1'b0, 1'b1, 16'h0A18, 32'h1234);
    chk("wrhit_cyc", 32'(r_cyc), 32'd1);
    chk("wrhit_hit", 32'(r_hit), 32'd1);
    run_req(1'b1, 1'b0, 16'h0A18, 32'h0);
    chk("rdhit_cyc",   32'(r_cyc), 32'd1);
    chk("rdhit_rdata", r_rdata,    32'h0000_1234);
    chk("rdhit_hit",   32'(r_hit), 32'd1);

    // dirty miss: write-back then fill
    wr0 = wr_count;
    run_req(1'b1, 1'b0, 16'h1A18, 32'h0);
    chk("dirty_cyc",   32'(r_cyc), 32'd10);
    chk("dirty_rdata", r_rdata,    32'h0000_1A18);
    chk("dirty_hit",   32'(r_hit), 32'd0);
    chk("wb_count",    32'(wr_count - wr0), 32'd4);
    chk("wb_0a18",     mem_m[16'h0A18], 32'h0000_1234);
    chk("wb_0a10",     mem_m[16'h0A10], 32'h0000_0A10);

    // error requests
    run_req(1'b1, 1'b0, 16'h0A1A, 32'h0);
    chk("mis_cyc", 32'(r_cyc), 32'd1);
    chk("mis_err", 32'(r_err), 32'd1);
    chk("mis_bus", 32'(r_saw), 32'd0);
    run_req(1'b1, 1'b1, 16'h0A18, 32'h0);
    chk("rdwr_cyc", 32'(r_cyc), 32'd1);
    chk("rdwr_err", 32'(r_err), 32'd1);
    chk("rdwr_hit", 32'(r_hit), 32'd0);
    chk("rdwr_bus", 32'(r_saw), 32'd0);

    // write miss commits in RETRY
    run_req(1'b0, 1'b1, 16'h4C04, 32'hCAFE);
    chk("wrmiss_cyc", 32'(r_cyc), 32'd6);
    chk("wrmiss_hit", 32'(r_hit), 32'd0);
    run_req(1'b1, 1'b0, 16'h4C04, 32'h0);
    chk("wrmiss_rd", r_rdata, 32'h0000_CAFE);

    // stretched transfers
    mem_delay = 3;
    run_req(1'b1, 1'b0, 16'h3B00, 32'h0);
    chk("slow_cyc",   32'(r_cyc), 32'd18);
    chk("slow_rdata", r_rdata,    32'h0000_3B00);

    // async reset during FILL2
    @(posedge clk); #1;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 16'h2A18;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 16'h2A18) begin
        found = 1'b1;
        break;
      end
    end
    chk("fill2_seen", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_memreq", 32'(bus.mem_req),    32'd0);
    chk("arst_addr",   32'(bus.mem_addr),   32'd0);
    chk("arst_cen",    32'(bus.c_enable),   32'd0);
    chk("arst_stall",  32'(bus.cpu_stall),  32'd0);
    chk("arst_hitcnt", 32'(bus.hit_count),  32'd0);
    chk("arst_miscnt", 32'(bus.miss_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_delay = 0;

    // after reset the line is gone: miss, then two hits
    run_req(1'b1, 1'b0, 16'h2A18, 32'h0);
    chk("post_cyc",   32'(r_cyc), 32'd6);
    chk("post_hit",   32'(r_hit), 32'd0);
    chk("post_rdata", r_rdata,    32'h0000_2A18);
    run_req(1'b1, 1'b0, 16'h2A18, 32'h0);
    chk("hit1", 32'(r_hit), 32'd1);
    run_req(1'b1, 1'b0, 16'h2A1C, 32'h0);
    chk("hit2",       32'(r_hit), 32'd1);
    chk("hit2_rdata", r_rdata,    32'h0000_2A1C);

`ifdef CACHE_CTRL_STATS_EN
    exp_hits = 16'd2;
    exp_miss = 16'd1;
`else
    exp_hits = 16'd0;
    exp_miss = 16'd0;
`endif
    @(negedge clk);
    chk("hit_count",  32'(bus.hit_count),  32'(exp_hits));
    chk("miss_count", 32'(bus.miss_count), 32'(exp_miss));
    chk("mem_stable", 32'(unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
